// File: rtl/siggen_pkg.sv
// ---------------------------------------------------------------------------
// siggen_pkg
// Shared types and default sizes for the sine-ROM sequencer (siggen_ctrl)
// and its rate divider (tick_gen).
//   ctrl_state_t : sequencer states, also driven out on siggen_ctrl.dbg_state
//   *_DEF        : default address / divider / burst-length widths
// ---------------------------------------------------------------------------
package siggen_pkg;

    localparam int WIDTH_DEF     = 8;
    localparam int DIV_WIDTH_DEF = 16;
    localparam int LEN_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/siggen_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
// Programmable rate divider. It owns the divide counter and makes the
// combinational tick decision for the current cycle. The parent registers
// the decision to form the counter enable.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clear    : treat the count as 0 this cycle (the start cycle of a run)
//   hold     : freeze the count and suppress the tick (pause / not running)
//   period   : tick period minus 1
//   tick     : this cycle's decision; the count then restarts from 0
// ---------------------------------------------------------------------------
module tick_gen
    import siggen_pkg::*;
#(
    parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 hold,
    input  logic [DIV_WIDTH-1:0] period,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [DIV_WIDTH-1:0] w_cnt_eff;

    // The start cycle already counts as the first divider cycle, so the
    // first tick lands period+1 cycles after start.
    assign w_cnt_eff = clear ? '0 : r_div_cnt;
    assign tick      = ~hold & (w_cnt_eff == period);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (hold) begin
            r_div_cnt <= w_cnt_eff;
        end else if (tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= w_cnt_eff + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/siggen_ctrl.sv
// ---------------------------------------------------------------------------
// siggen_ctrl
// Sequencer for the dual-address sine-ROM counter. It issues the counter's
// en tick at a programmable rate, in continuous or fixed-length burst mode,
// and forwards phase-offset (diff) updates glitch-free.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start / stop        : start request (IDLE only) / abort (RUN only)
//   pause               : level, freezes ticking in RUN
//   burst, burst_len    : burst mode and length, sampled at start
//   rate_div            : tick period minus 1, sampled at start
//   cfg_diff/valid/ready: phase-offset update handshake
//   count1              : counter's current base address
//   en, diff            : registered enable tick and phase offset to counter
//   busy, done, samples : status (busy/done are registered copies of state)
//   dbg_state           : current FSM state
// Build option: SIGGEN_CTRL_WRAP_SYNC_EN -- when defined, a pending diff is
// applied only at an address wrap (en=1 with count1 all ones); otherwise it
// is applied at the next en tick and count1 is unused.
// ---------------------------------------------------------------------------
module siggen_ctrl
    import siggen_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DIV_WIDTH = DIV_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 pause,
    input  logic                 burst,
    input  logic [LEN_WIDTH-1:0] burst_len,
    input  logic [DIV_WIDTH-1:0] rate_div,
    input  logic [WIDTH-1:0]     cfg_diff,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WIDTH-1:0]     count1,
    output logic                 en,
    output logic [WIDTH-1:0]     diff,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] samples,
    output logic [1:0]           dbg_state
);

    ctrl_state_t          r_state, w_next_state;
    logic                 r_burst_l;
    logic [LEN_WIDTH-1:0] r_len_l;
    logic [DIV_WIDTH-1:0] r_rate_l;
    logic                 r_en, r_busy, r_done, r_pending;
    logic [LEN_WIDTH-1:0] r_samples;
    logic [WIDTH-1:0]     r_diff, r_pending_diff;

    logic                 w_start_go, w_zero_burst, w_active, w_hold, w_tick;
    logic                 w_burst_sel, w_last, w_xfer, w_leaving_run, w_apply_pt;
    logic [DIV_WIDTH-1:0] w_period;
    logic [LEN_WIDTH-1:0] w_len_sel, w_samples_base, w_samples_inc;
    logic                 w_en_d, w_busy_d, w_done_d;
    logic [LEN_WIDTH-1:0] w_samples_d;

    // In the start cycle the fresh inputs are used directly so the first
    // tick decision is made in that very cycle.
    assign w_start_go     = (r_state == S_IDLE) & start;
    assign w_zero_burst   = burst & (burst_len == '0);
    assign w_period       = w_start_go ? rate_div  : r_rate_l;
    assign w_burst_sel    = w_start_go ? burst     : r_burst_l;
    assign w_len_sel      = w_start_go ? burst_len : r_len_l;
    assign w_samples_base = w_start_go ? '0        : r_samples;
    assign w_samples_inc  = w_samples_base + LEN_WIDTH'(1);
    assign w_active       = w_start_go ? ~w_zero_burst
                                       : ((r_state == S_RUN) & ~stop & ~pause);
    assign w_hold         = ~w_active;
    assign w_last         = w_tick & w_burst_sel & (w_samples_inc == w_len_sel);

    tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_start_go),
        .hold   (w_hold),
        .period (w_period),
        .tick   (w_tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state logic; start beats a simultaneous stop because stop is
    // only looked at in RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_zero_burst || w_last) w_next_state = S_DONE;
                    else                        w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (stop)        w_next_state = S_IDLE;
                else if (w_last) w_next_state = S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output logic. busy/done follow the current state through a register,
    // so they trail the state by one cycle; en/samples follow the tick.
    always_comb begin
        w_en_d      = w_tick;
        w_samples_d = w_tick ? w_samples_inc : w_samples_base;
        w_busy_d    = (r_state == S_RUN);
        w_done_d    = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_samples <= '0;
            r_burst_l <= 1'b0;
            r_len_l   <= '0;
            r_rate_l  <= '0;
        end else begin
            r_en      <= w_en_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_samples <= w_samples_d;
            if (w_start_go) begin
                r_burst_l <= burst;
                r_len_l   <= burst_len;
                r_rate_l  <= rate_div;
            end
        end
    end

    // Config handshake: a transfer happens on every cycle with
    // cfg_valid && cfg_ready; cfg_ready is low only while an update is
    // pending. Outside RUN (or when RUN is being left this cycle) the value
    // goes straight to diff; in RUN it waits for the apply point so the
    // counter never sees diff change mid-cycle of the waveform.
`ifdef SIGGEN_CTRL_WRAP_SYNC_EN
    assign w_apply_pt = r_en & (count1 == '1);
`else
    logic w_unused_count1;
    assign w_unused_count1 = ^count1;
    assign w_apply_pt      = r_en;
`endif
    assign w_xfer        = cfg_valid & ~r_pending;
    assign w_leaving_run = (r_state == S_RUN) & (w_next_state != S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_diff         <= '0;
            r_pending_diff <= '0;
            r_pending      <= 1'b0;
        end else if (w_xfer) begin
            if ((r_state == S_RUN) && !w_leaving_run) begin
                r_pending_diff <= cfg_diff;
                r_pending      <= 1'b1;
            end else begin
                r_diff <= cfg_diff;
            end
        end else if (r_pending && (w_apply_pt || w_leaving_run)) begin
            r_diff    <= r_pending_diff;
            r_pending <= 1'b0;
        end
    end

    assign en        = r_en;
    assign diff      = r_diff;
    assign busy      = r_busy;
    assign done      = r_done;
    assign samples   = r_samples;
    assign cfg_ready = ~r_pending;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_siggen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_siggen_ctrl
// Directed bench for siggen_ctrl. Inputs are driven 1 time unit after each
// rising edge; "cycle c" is the interval after the c-th edge counted from
// the start request (cycle 0). Outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_siggen_ctrl;

    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 16;
    localparam int LEN_WIDTH = 16;

    logic                 clk       = 1'b0;
    logic                 rst       = 1'b0;
    logic                 start     = 1'b0;
    logic                 stop      = 1'b0;
    logic                 pause     = 1'b0;
    logic                 burst     = 1'b0;
    logic [LEN_WIDTH-1:0] burst_len = '0;
    logic [DIV_WIDTH-1:0] rate_div  = '0;
    logic [WIDTH-1:0]     cfg_diff  = '0;
    logic                 cfg_valid = 1'b0;
    logic [WIDTH-1:0]     count1    = '0;
    logic                 cfg_ready, en, busy, done;
    logic [WIDTH-1:0]     diff;
    logic [LEN_WIDTH-1:0] samples;
    logic [1:0]           dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    siggen_ctrl #(
        .WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH), .LEN_WIDTH(LEN_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .burst(burst), .burst_len(burst_len), .rate_div(rate_div),
        .cfg_diff(cfg_diff), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .count1(count1), .en(en), .diff(diff), .busy(busy), .done(done),
        .samples(samples), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Expected diff / cfg_ready in cycle k+j of the phase-update run
    // (en every cycle, count1 = 250+j, 0x40 offered in k, 0x99 offered in
    // k+1..k+6, stop in k+8).
    function automatic logic [7:0] exp_diff_at(int j);
`ifdef SIGGEN_CTRL_WRAP_SYNC_EN
        if (j <= 5)      return 8'h11;
        else if (j <= 8) return 8'h40;
        else             return 8'h99;
`else
        if (j == 1)      return 8'h11;
        else if (j <= 3) return 8'h40;
        else             return 8'h99;
`endif
    endfunction

    function automatic logic exp_ready_at(int j);
`ifdef SIGGEN_CTRL_WRAP_SYNC_EN
        return (j == 6) || (j == 9);
`else
        return ((j % 2) == 0) || (j == 9);
`endif
    endfunction

    initial begin
        // ---- reset values ----
        #1 rst = 1'b1;
        #1;
        check("rst_en", en, 0);
        check("rst_diff", diff, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_samples", samples, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_state", dbg_state, 0);
        step();
        step();
        rst = 1'b0;
        step();

        // ---- config transfer while idle goes straight to diff ----
        cfg_diff = 8'h11; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("idle_cfg_diff", diff, 8'h11);
        check("idle_cfg_ready", cfg_ready, 1);

        // ---- continuous, rate_div=2, pause in cycles 4..7 ----
        burst = 1'b0; rate_div = 16'd2; start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            start = 1'b0;
            check("cont_en", en, (c == 3 || c == 10 || c == 13));
            check("cont_samples", samples, (c < 3) ? 0 : (c < 10) ? 1 : (c < 13) ? 2 : 3);
            if (c >= 2) check("cont_busy", busy, 1);
            pause = (c >= 4 && c <= 7);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("cont_stop_en", en, 0);
        check("cont_stop_samples", samples, 3);
        step();
        check("cont_stop_busy", busy, 0);
        check("cont_stop_state", dbg_state, 0);

        // ---- burst of 5, rate_div=0 ----
        burst = 1'b1; burst_len = 16'd5; rate_div = 16'd0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            start = 1'b0;
            check("burst5_en", en, (c <= 5));
            check("burst5_samples", samples, (c <= 5) ? c : 5);
            check("burst5_done", done, (c == 6));
            if (c == 6) check("burst5_busy", busy, 0);
        end

        // ---- burst of 0: no ticks, done pulse only ----
        burst = 1'b1; burst_len = 16'd0; rate_div = 16'd0; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            check("burst0_en", en, 0);
            check("burst0_done", done, (c == 2));
            check("burst0_samples", samples, 0);
        end

        // ---- burst of 100 stopped at sample 40 ----
        burst = 1'b1; burst_len = 16'd100; rate_div = 16'd0; start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            start = 1'b0;
            if (c == 40) begin
                check("stop40_en_before", en, 1);
                check("stop40_samples_before", samples, 40);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop40_en", en, 0);
        check("stop40_samples", samples, 40);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stop40_no_done", done, 0);
            check("stop40_no_en", en, 0);
        end

        // ---- start and stop together in idle: RUN wins ----
        burst = 1'b0; rate_div = 16'd0; start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        step();
        check("startstop_en", en, 1);
        check("startstop_busy", busy, 1);
        check("startstop_samples", samples, 2);

        // ---- phase update in RUN, count1 walking 250..255..0 ----
        count1 = 8'd250; cfg_diff = 8'h40; cfg_valid = 1'b1;
        for (int j = 1; j <= 9; j++) begin
            step();
            check("run_cfg_diff", diff, exp_diff_at(j));
            check("run_cfg_ready", cfg_ready, exp_ready_at(j));
            count1    = 8'(250 + j);
            cfg_diff  = 8'h99;
            cfg_valid = (j <= 6);
            stop      = (j == 8);
        end
        stop = 1'b0; cfg_valid = 1'b0;

        // ---- pending update flushed by stop before any tick ----
        burst = 1'b0; rate_div = 16'd20; start = 1'b1;
        step();
        start = 1'b0;
        cfg_diff = 8'h5A; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        check("flush_ready_low", cfg_ready, 0);
        check("flush_diff_old", diff, 8'h99);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("flush_diff_new", diff, 8'h5A);
        check("flush_ready_high", cfg_ready, 1);
        check("flush_en", en, 0);

        // ---- reset in the middle of a run, rate_div=3 ----
        burst = 1'b0; rate_div = 16'd3; start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            start = 1'b0;
        end
        check("midrst_en_before", en, 1);
        check("midrst_samples_before", samples, 1);
        rst = 1'b1;
        #1;
        check("midrst_en", en, 0);
        check("midrst_samples", samples, 0);
        check("midrst_busy", busy, 0);
        check("midrst_diff", diff, 0);
        check("midrst_cfg_ready", cfg_ready, 1);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("midrst_no_en", en, 0);
            check("midrst_idle", dbg_state, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
